// File: rtl/memory_access_stage.sv
// RV32I MEM stage: one data-bus transaction per load/store, load alignment/extension, registered MEM->WB payload.
// Latency: 1 cycle for non-memory ops, >=2 cycles for loads/stores. memoryStall holds upstream while a bus access is outstanding.
package memory_access_stage_pkg;
    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_MEM  = 2'd2;
    localparam logic [1:0] WB_PC4  = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] programCounter;
        logic [31:0] programCounterPlus4;
        logic [31:0] result;
        logic [31:0] storeData;
        logic [4:0]  destinationRegister;
        logic        memoryReadEnable;
        logic        memoryWriteEnable;
        logic [1:0]  memoryWidth;
        logic        memorySigned;
        logic [1:0]  writebackType;
        logic        illegal;
        logic [11:0] destinationCSR;
        logic [31:0] oldCSRValue;
        logic [1:0]  CSROp;
        logic        CSRWriteIntent;
    } executeMemoryPayload_;

    typedef struct packed {
        logic        valid;
        logic [31:0] programCounter;
        logic [31:0] data;
        logic [4:0]  destinationRegister;
        logic        writebackEnable;
        logic        illegal;
        logic [11:0] destinationCSR;
        logic [31:0] oldCSRValue;
        logic [1:0]  CSROp;
        logic        CSRWriteIntent;
    } memoryWritebackPayload_;
endpackage

module memory_access_stage
    import memory_access_stage_pkg::*;
(
    input  logic                   clock,
    input  logic                   resetN,
    input  executeMemoryPayload_   executeMemoryPayload,
    input  logic                   flush,
    output logic                   memoryStall,
    output logic                   dataRequest,
    output logic                   dataWrite,
    output logic [31:0]            dataAddress,
    output logic [3:0]             dataByteEnable,
    output logic [31:0]            dataWriteData,
    input  logic                   dataGrant,
    input  logic                   dataResponseValid,
    input  logic [31:0]            dataReadData,
    input  logic                   dataError,
    output memoryWritebackPayload_ memoryWritebackPayload,
    output logic                   loadMisaligned,
    output logic                   storeMisaligned,
    output logic                   accessFault
);
    typedef enum logic [1:0] {IDLE, REQUEST, RESPONSE, DRAIN} state_;

    state_                  state, nextState;
    memoryWritebackPayload_ nextPayload;
    logic                   nextLoadMisaligned, nextStoreMisaligned, nextAccessFault;
    logic                   memoryOp, misaligned, alignedOp, responseDone;
    logic [31:0]            shiftedRead, loadData;

    always_comb begin
        memoryOp = executeMemoryPayload.valid &&
                   (executeMemoryPayload.memoryReadEnable || executeMemoryPayload.memoryWriteEnable);
        unique case (executeMemoryPayload.memoryWidth)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = executeMemoryPayload.result[0];
            2'b10:   misaligned = executeMemoryPayload.result[1:0] != 2'b00;
            default: misaligned = 1'b1;
        endcase
        misaligned   = misaligned && memoryOp;
        alignedOp    = memoryOp && !misaligned;
        responseDone = (state == RESPONSE) && dataResponseValid;
    end

    // Bus side: address/enables/data are pure functions of the held payload, so they stay stable until response.
    always_comb begin
        dataRequest    = !flush && alignedOp && (state == IDLE || state == REQUEST);
        dataWrite      = executeMemoryPayload.memoryWriteEnable;
        dataAddress    = {executeMemoryPayload.result[31:2], 2'b00};
        memoryStall    = !flush && alignedOp && !responseDone;
        unique case (executeMemoryPayload.memoryWidth)
            2'b00: begin
                dataByteEnable = 4'b0001 << executeMemoryPayload.result[1:0];
                dataWriteData  = {4{executeMemoryPayload.storeData[7:0]}};
            end
            2'b01: begin
                dataByteEnable = 4'b0011 << executeMemoryPayload.result[1:0];
                dataWriteData  = {2{executeMemoryPayload.storeData[15:0]}};
            end
            default: begin
                dataByteEnable = 4'b1111;
                dataWriteData  = executeMemoryPayload.storeData;
            end
        endcase
    end

    always_comb begin
        shiftedRead = dataReadData >> {executeMemoryPayload.result[1:0], 3'b000};
        unique case (executeMemoryPayload.memoryWidth)
            2'b00:   loadData = {{24{executeMemoryPayload.memorySigned & shiftedRead[7]}}, shiftedRead[7:0]};
            2'b01:   loadData = {{16{executeMemoryPayload.memorySigned & shiftedRead[15]}}, shiftedRead[15:0]};
            default: loadData = shiftedRead;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:     if (alignedOp && !flush) nextState = dataGrant ? RESPONSE : REQUEST;
            REQUEST:  if (flush) nextState = IDLE;
                      else if (dataGrant) nextState = RESPONSE;
            RESPONSE: if (dataResponseValid) nextState = IDLE;
                      else if (flush) nextState = DRAIN;
            DRAIN:    if (dataResponseValid) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Faults keep the pass-through fields so WB can report a precise trap with the right PC.
    always_comb begin
        nextPayload         = '0;
        nextLoadMisaligned  = 1'b0;
        nextStoreMisaligned = 1'b0;
        nextAccessFault     = 1'b0;
        if (!flush && (!alignedOp || responseDone)) begin
            nextPayload.valid               = executeMemoryPayload.valid;
            nextPayload.programCounter      = executeMemoryPayload.programCounter;
            nextPayload.destinationRegister = executeMemoryPayload.destinationRegister;
            nextPayload.illegal             = executeMemoryPayload.illegal;
            nextPayload.destinationCSR      = executeMemoryPayload.destinationCSR;
            nextPayload.oldCSRValue         = executeMemoryPayload.oldCSRValue;
            nextPayload.CSROp               = executeMemoryPayload.CSROp;
            nextPayload.CSRWriteIntent      = executeMemoryPayload.CSRWriteIntent;
            unique case (executeMemoryPayload.writebackType)
                WB_MEM:  nextPayload.data = loadData;
                WB_PC4:  nextPayload.data = executeMemoryPayload.programCounterPlus4;
                default: nextPayload.data = executeMemoryPayload.result;
            endcase
            if (misaligned || (alignedOp && dataError)) begin
                nextPayload.illegal = 1'b1;
                nextPayload.data    = executeMemoryPayload.result;
                nextLoadMisaligned  = misaligned && executeMemoryPayload.memoryReadEnable;
                nextStoreMisaligned = misaligned && !executeMemoryPayload.memoryReadEnable;
                nextAccessFault     = !misaligned;
            end
            nextPayload.writebackEnable = nextPayload.valid && !nextPayload.illegal &&
                                          executeMemoryPayload.writebackType != WB_NONE &&
                                          executeMemoryPayload.destinationRegister != 5'd0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            memoryWritebackPayload <= '0;
            loadMisaligned         <= 1'b0;
            storeMisaligned        <= 1'b0;
            accessFault            <= 1'b0;
        end else begin
            memoryWritebackPayload <= nextPayload;
            loadMisaligned         <= nextLoadMisaligned;
            storeMisaligned        <= nextStoreMisaligned;
            accessFault            <= nextAccessFault;
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a spec-level result model and a per-cycle scoreboard compare.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic clock = 1'b0;
    logic resetN;
    executeMemoryPayload_   executeMemoryPayload;
    logic flush, memoryStall, dataRequest, dataWrite;
    logic [31:0] dataAddress, dataWriteData, dataReadData;
    logic [3:0]  dataByteEnable;
    logic dataGrant, dataResponseValid, dataError;
    memoryWritebackPayload_ memoryWritebackPayload;
    logic loadMisaligned, storeMisaligned, accessFault;

    memory_access_stage dut (
        .clock(clock), .resetN(resetN), .executeMemoryPayload(executeMemoryPayload), .flush(flush),
        .memoryStall(memoryStall), .dataRequest(dataRequest), .dataWrite(dataWrite),
        .dataAddress(dataAddress), .dataByteEnable(dataByteEnable), .dataWriteData(dataWriteData),
        .dataGrant(dataGrant), .dataResponseValid(dataResponseValid), .dataReadData(dataReadData),
        .dataError(dataError), .memoryWritebackPayload(memoryWritebackPayload),
        .loadMisaligned(loadMisaligned), .storeMisaligned(storeMisaligned), .accessFault(accessFault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        memoryWritebackPayload_ p;
        logic lm, sm, af;
    } expect_;

    int     testsRun = 0;
    int     testsFailed = 0;
    expect_ expectQ[$];

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    function automatic executeMemoryPayload_ mk(input logic [31:0] pc, input logic [31:0] result,
            input logic [31:0] storeData, input logic [4:0] rd, input logic re, input logic we,
            input logic [1:0] width, input logic sgn, input logic [1:0] wbType);
        executeMemoryPayload_ p;
        p = '0;
        p.valid = 1'b1;
        p.programCounter = pc;
        p.programCounterPlus4 = pc + 32'd4;
        p.result = result;
        p.storeData = storeData;
        p.destinationRegister = rd;
        p.memoryReadEnable = re;
        p.memoryWriteEnable = we;
        p.memoryWidth = width;
        p.memorySigned = sgn;
        p.writebackType = wbType;
        p.destinationCSR = 12'h300;
        p.oldCSRValue = pc ^ 32'h5A5A_0000;
        p.CSROp = 2'd2;
        return p;
    endfunction

    // What WB must see for an instruction, given the bus response it received.
    function automatic expect_ model(input executeMemoryPayload_ p, input logic [31:0] rdata, input logic err);
        expect_ e;
        int size, offset;
        logic [31:0] shifted;
        longint v;
        logic isMem, isMis;
        e = '0;
        e.p.valid = p.valid;
        e.p.programCounter = p.programCounter;
        e.p.destinationRegister = p.destinationRegister;
        e.p.illegal = p.illegal;
        e.p.destinationCSR = p.destinationCSR;
        e.p.oldCSRValue = p.oldCSRValue;
        e.p.CSROp = p.CSROp;
        e.p.CSRWriteIntent = p.CSRWriteIntent;
        isMem = p.valid && (p.memoryReadEnable || p.memoryWriteEnable);
        size = (p.memoryWidth == 2'd3) ? 0 : (1 << p.memoryWidth);
        isMis = isMem && (size == 0 || (p.result % size) != 0);
        if (isMis || (isMem && err)) begin
            e.p.illegal = 1'b1;
            e.p.data = p.result;
            e.lm = isMis && p.memoryReadEnable;
            e.sm = isMis && !p.memoryReadEnable;
            e.af = !isMis;
            return e;
        end
        offset = int'(p.result % 4);
        shifted = rdata >> (8 * offset);
        v = longint'(shifted) & ((longint'(1) << (8 * size)) - 1);
        if (p.memorySigned && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
        if (p.writebackType == WB_MEM)      e.p.data = v[31:0];
        else if (p.writebackType == WB_PC4) e.p.data = p.programCounterPlus4;
        else                                e.p.data = p.result;
        e.p.writebackEnable = p.valid && !p.illegal && p.writebackType != WB_NONE && p.destinationRegister != 0;
        return e;
    endfunction

    initial begin : compare
        expect_ e;
        forever begin
            @(posedge clock);
            #2;
            if (resetN === 1'b1) begin
                if (memoryWritebackPayload.valid) begin
                    if (expectQ.size() == 0) begin
                        check("unexpected_output", memoryWritebackPayload, 128'd0);
                    end else begin
                        e = expectQ.pop_front();
                        check("wb_payload", memoryWritebackPayload, e.p);
                        check("fault_flags", {loadMisaligned, storeMisaligned, accessFault}, {e.lm, e.sm, e.af});
                    end
                end else begin
                    check("bubble_flags", {loadMisaligned, storeMisaligned, accessFault}, 3'b000);
                end
            end
        end
    end

    task automatic memTxn(input executeMemoryPayload_ p, input int grantDelay, input int respDelay,
            input logic [31:0] rdata, input logic err, output int reqCycles,
            output logic [31:0] addr, output logic [3:0] be, output logic [31:0] wd, output logic wr);
        executeMemoryPayload = p;
        reqCycles = 0;
        addr = '0; be = '0; wd = '0; wr = 1'b0;
        for (int c = 0; c <= grantDelay; c++) begin
            dataGrant = (c == grantDelay);
            @(negedge clock);
            if (dataRequest) reqCycles++;
            if (c == 0) begin
                addr = dataAddress; be = dataByteEnable; wd = dataWriteData; wr = dataWrite;
            end else begin
                check("bus_stable", {dataAddress, dataByteEnable, dataWriteData}, {addr, be, wd});
            end
            check("stall_in_request", memoryStall, 1'b1);
            @(posedge clock); #1;
        end
        dataGrant = 1'b0;
        for (int c = 0; c < respDelay; c++) begin
            @(negedge clock);
            check("no_request_in_response", dataRequest, 1'b0);
            check("stall_in_response", memoryStall, 1'b1);
            @(posedge clock); #1;
        end
        dataResponseValid = 1'b1;
        dataReadData = rdata;
        dataError = err;
        @(negedge clock);
        check("stall_released", memoryStall, 1'b0);
        @(posedge clock); #1;
        dataResponseValid = 1'b0;
        dataError = 1'b0;
        executeMemoryPayload = '0;
    endtask

    initial begin : stimulus
        executeMemoryPayload_ p, p2;
        expect_ m;
        int reqCycles;
        logic [31:0] addr, wd;
        logic [3:0] be;
        logic wr;

        resetN = 1'b0;
        executeMemoryPayload = '0;
        flush = 1'b0;
        dataGrant = 1'b0;
        dataResponseValid = 1'b0;
        dataReadData = '0;
        dataError = 1'b0;
        #3;
        check("reset_payload", memoryWritebackPayload, 128'd0);
        check("reset_flags", {loadMisaligned, storeMisaligned, accessFault, dataRequest}, 4'd0);
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock); #1;

        // Pin the model against hand-computed values.
        m = model(mk(32'h40, 32'h8000_0002, 0, 5'd3, 1, 0, 2'd0, 1, WB_MEM), 32'h0080_0000, 1'b0);
        check("model_lb", m.p.data, 32'hFFFF_FF80);
        m = model(mk(32'h40, 32'h8000_0002, 0, 5'd3, 1, 0, 2'd0, 0, WB_MEM), 32'h0080_0000, 1'b0);
        check("model_lbu", m.p.data, 32'h0000_0080);
        m = model(mk(32'h40, 32'h8000_0002, 0, 5'd3, 1, 0, 2'd2, 0, WB_MEM), 32'h0, 1'b0);
        check("model_misaligned", {m.p.illegal, m.lm, m.p.writebackEnable}, 3'b110);

        // Ungranted lw: grant after 3 extra cycles.
        p = mk(32'h100, 32'h8000_0104, 0, 5'd5, 1, 0, 2'd2, 1, WB_MEM);
        expectQ.push_back(model(p, 32'hDEAD_BEEF, 1'b0));
        memTxn(p, 3, 0, 32'hDEAD_BEEF, 1'b0, reqCycles, addr, be, wd, wr);
        check("lw_request_cycles", reqCycles, 4);
        check("lw_address", addr, 32'h8000_0104);
        check("lw_data", memoryWritebackPayload.data, 32'hDEAD_BEEF);
        check("lw_wbe", memoryWritebackPayload.writebackEnable, 1'b1);

        // lb / lbu at byte lane 2, one response wait cycle.
        p = mk(32'h104, 32'h8000_0002, 0, 5'd6, 1, 0, 2'd0, 1, WB_MEM);
        expectQ.push_back(model(p, 32'h0080_0000, 1'b0));
        memTxn(p, 0, 1, 32'h0080_0000, 1'b0, reqCycles, addr, be, wd, wr);
        check("lb_data", memoryWritebackPayload.data, 32'hFFFF_FF80);
        check("lb_enable", be, 4'b0100);
        p = mk(32'h108, 32'h8000_0002, 0, 5'd7, 1, 0, 2'd0, 0, WB_MEM);
        expectQ.push_back(model(p, 32'h0080_0000, 1'b0));
        memTxn(p, 0, 0, 32'h0080_0000, 1'b0, reqCycles, addr, be, wd, wr);
        check("lbu_data", memoryWritebackPayload.data, 32'h0000_0080);

        // sh at upper half.
        p = mk(32'h10C, 32'h8000_0006, 32'h1234_ABCD, 5'd0, 0, 1, 2'd1, 0, WB_NONE);
        expectQ.push_back(model(p, 32'h0, 1'b0));
        memTxn(p, 1, 0, 32'h0, 1'b0, reqCycles, addr, be, wd, wr);
        check("sh_write", wr, 1'b1);
        check("sh_enable", be, 4'b1100);
        check("sh_wdata", wd, 32'hABCD_ABCD);
        check("sh_address", addr, 32'h8000_0004);
        check("sh_wbe", memoryWritebackPayload.writebackEnable, 1'b0);

        // Misaligned lw: no bus access, fault next cycle.
        p = mk(32'h110, 32'h8000_0002, 0, 5'd8, 1, 0, 2'd2, 1, WB_MEM);
        executeMemoryPayload = p;
        expectQ.push_back(model(p, 32'h0, 1'b0));
        @(negedge clock);
        check("mis_no_request", {dataRequest, memoryStall}, 2'b00);
        @(posedge clock); #1;
        check("mis_flag", {loadMisaligned, memoryWritebackPayload.illegal}, 2'b11);
        executeMemoryPayload = '0;

        // Flush while in REQUEST.
        p = mk(32'h114, 32'h8000_0010, 0, 5'd9, 1, 0, 2'd2, 0, WB_MEM);
        executeMemoryPayload = p;
        @(posedge clock); #1;
        flush = 1'b1;
        @(negedge clock);
        check("flush_request_gated", {dataRequest, memoryStall}, 2'b00);
        @(posedge clock); #1;
        check("flush_bubble", memoryWritebackPayload.valid, 1'b0);
        flush = 1'b0;
        // Following load gets a bus error; request must start right away from IDLE.
        p2 = mk(32'h118, 32'h8000_0020, 0, 5'd10, 1, 0, 2'd2, 0, WB_MEM);
        expectQ.push_back(model(p2, 32'h0, 1'b1));
        memTxn(p2, 0, 0, 32'h0, 1'b1, reqCycles, addr, be, wd, wr);
        check("err_request_from_idle", reqCycles, 1);
        check("err_fault", {accessFault, memoryWritebackPayload.writebackEnable}, 2'b10);

        // Flush in RESPONSE: DRAIN swallows the stale response before a new op may issue.
        executeMemoryPayload = p;
        dataGrant = 1'b1;
        @(posedge clock); #1;
        dataGrant = 1'b0;
        flush = 1'b1;
        @(negedge clock);
        check("resp_flush_no_request", dataRequest, 1'b0);
        @(posedge clock); #1;
        flush = 1'b0;
        p2 = mk(32'h11C, 32'h8000_0030, 0, 5'd11, 1, 0, 2'd2, 0, WB_MEM);
        executeMemoryPayload = p2;
        @(negedge clock);
        check("drain_hold", {dataRequest, memoryStall}, 2'b01);
        @(posedge clock); #1;
        dataResponseValid = 1'b1;
        dataReadData = 32'hBAD0_BAD0;
        @(negedge clock);
        check("drain_discard", {dataRequest, memoryStall}, 2'b01);
        @(posedge clock); #1;
        dataResponseValid = 1'b0;
        expectQ.push_back(model(p2, 32'h0000_1234, 1'b0));
        memTxn(p2, 0, 0, 32'h0000_1234, 1'b0, reqCycles, addr, be, wd, wr);
        check("after_drain_data", memoryWritebackPayload.data, 32'h0000_1234);

        // Flush coincident with response: consumed, bubble, back to IDLE.
        executeMemoryPayload = p;
        dataGrant = 1'b1;
        @(posedge clock); #1;
        dataGrant = 1'b0;
        flush = 1'b1;
        dataResponseValid = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        dataResponseValid = 1'b0;
        check("flush_resp_bubble", memoryWritebackPayload.valid, 1'b0);
        executeMemoryPayload = p;
        @(negedge clock);
        check("flush_resp_idle", dataRequest, 1'b1);
        @(posedge clock); #1;
        executeMemoryPayload = '0;

        // Back-to-back: ALU with rd=0, then jal.
        p = mk(32'h200, 32'h0000_0055, 0, 5'd0, 0, 0, 2'd2, 0, WB_ALU);
        executeMemoryPayload = p;
        expectQ.push_back(model(p, 32'h0, 1'b0));
        @(negedge clock);
        check("alu_no_stall", memoryStall, 1'b0);
        @(posedge clock); #1;
        check("alu_wbe", memoryWritebackPayload.writebackEnable, 1'b0);
        p = mk(32'h204, 32'h0000_0300, 0, 5'd1, 0, 0, 2'd2, 0, WB_PC4);
        executeMemoryPayload = p;
        expectQ.push_back(model(p, 32'h0, 1'b0));
        @(posedge clock); #1;
        check("jal_result", {memoryWritebackPayload.writebackEnable, memoryWritebackPayload.data}, {1'b1, 32'h208});

        // Asynchronous reset mid-RESPONSE.
        p = mk(32'h208, 32'h8000_0040, 0, 5'd12, 1, 0, 2'd2, 0, WB_MEM);
        executeMemoryPayload = p;
        dataGrant = 1'b1;
        @(posedge clock); #1;
        dataGrant = 1'b0;
        #2;
        resetN = 1'b0;
        executeMemoryPayload = '0;
        #1;
        check("async_reset_payload", memoryWritebackPayload, 128'd0);
        check("async_reset_ctrl",
              {loadMisaligned, storeMisaligned, accessFault, dataRequest, memoryStall}, 5'd0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (3) @(posedge clock);
        #3;
        check("queue_drained", expectQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
